reorder_buffer: RTL and testbench
=================================

REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 SHALL have parameter ROB_SIZE_BITS, default 3, meaning log2 of entry count (ROB_SIZE = 2**ROB_SIZE_BITS, legal 2..5).
REQ-002 SHALL have ports (B = ROB_SIZE_BITS):
- clk_in  in  1  system clock
- rst_in  in  1  synchronous active-high reset
- rdy_in  in  1  pause when low
- issue_valid  in  1  issue request
- issue_rd  in  5  destination reg
- issue_pc  in  32  instruction PC
- issue_pred_pc  in  32  predicted next PC
- issue_is_store  in  1  store instruction
- issue_ready  out  1  entry available
- issue_tag  out  B  tag assigned to the current issue (= tail)
- src1_reg / src2_reg  in  5  source reg lookup
- src1_pending / src2_pending  out  1  value not yet produced
- src1_tag / src2_tag  out  B  producer tag
- src1_from_rob / src2_from_rob  out  1  value supplied by buffer, not regfile
- src1_val / src2_val  out  32  forwarded value
- wb0_valid, wb1_valid  in  1  writeback strobes (0 = ALU, 1 = memory)
- wb0_tag, wb1_tag  in  B  writeback tag
- wb0_val, wb1_val  in  32  result
- wb0_next_pc, wb1_next_pc  in  32  actual next PC
- head_tag  out  B  oldest entry (store-at-head gating)
- commit_valid  out  1  head commits this cycle
- commit_rd  out  5  regfile write index
- commit_val  out  32  regfile write data
- commit_is_store  out  1  committing entry is a store
- flush_out  out  1  mispredict flush
- flush_pc  out  32  redirect PC
- count  out  B+1  occupied entries

Function
REQ-003 Each entry SHALL hold state EMPTY/ISSUED/DONE, rd, pc, pred_pc, actual_pc, value, is_store.
REQ-004 issue_ready SHALL be (count < ROB_SIZE); a commit in the same cycle SHALL NOT make a full buffer accept an issue.
REQ-005 On an edge with rdy_in=1, issue_valid=1, issue_ready=1 and no flush: entry[tail] <= ISSUED, tail <= tail+1 mod ROB_SIZE.
REQ-006 A wbN_valid SHALL set the tagged entry to DONE with value/actual_pc; a writeback to a non-ISSUED entry SHALL be ignored; if both ports target the same tag, port 0 SHALL win.
REQ-007 commit_valid SHALL be combinational: rdy_in && count>0 && entry[head]==DONE; commit_rd SHALL be 0 for stores.
REQ-008 On a commit edge: entry[head] <= EMPTY, head <= head+1 mod ROB_SIZE.
REQ-009 flush_out SHALL be commit_valid && actual_pc != pred_pc of head, with flush_pc = head actual_pc; the committing entry SHALL still write the regfile that cycle.
REQ-010 A flush edge SHALL clear all entries and the rename table and set head=tail=count=0; issue and writeback in that cycle SHALL be discarded.
REQ-011 Rename table: per arch reg busy+tag; an accepted issue with rd!=0 SHALL set busy[rd]=1, tag[rd]=tail.
REQ-012 A commit SHALL clear busy[rd] only if tag[rd]==head and no accepted issue in the same cycle writes the same rd.
REQ-013 Source lookup (combinational, per port): if reg==0 or not busy, then pending=0 and from_rob=0; else if producer is DONE, then pending=0, from_rob=1, val=entry value; else if a same-cycle wb matches the tag, then pending=0, from_rob=1, val=wb value (port 0 priority); else pending=1, tag=producer.
REQ-014 count SHALL update by +1 on issue, -1 on commit, net 0 on both.
REQ-015 head/tail SHALL wrap modulo ROB_SIZE; full is count==ROB_SIZE with head==tail.
REQ-016 rdy_in=0 SHALL freeze all state; commit_valid and flush_out SHALL be 0.

Reset
REQ-017 rst_in=1 at an edge SHALL clear all entries and rename busy bits and zero head, tail and count, taking precedence over rdy_in and every other input.
REQ-018 Outputs after reset: issue_ready=1, issue_tag=0, head_tag=0, count=0, commit_valid=0, flush_out=0, all src outputs pending=0/from_rob=0.

Verification
REQ-019 ROB_SIZE_BITS=3: issue 8 with no writeback -> count=8, issue_ready=0; a 9th issue with simultaneous head commit is rejected, count=7.
REQ-020 Issue x5 (tag 0), then lookup src1_reg=5 -> pending=1, tag=0; wb0 tag0 val 0x1234 same cycle -> pending=0, from_rob=1, val=0x1234.
REQ-021 Issue tags 0,1; wb tag1 then tag0 -> commit order tag0 then tag1, commit_val matches each.
REQ-022 Head pred_pc=0x104, wb actual 0x200 -> flush_out=1, flush_pc=0x200; next cycle count=0 and all lookups not pending.
REQ-023 Issue x3 at tag 2 and tag 4; commit tag 2 -> busy[x3] stays, tag=4; wb0 and wb1 both tag 4 -> value from wb0.
REQ-024 Hold rdy_in=0 with head DONE for 3 cycles -> commit_valid=0, count unchanged; rst_in mid-run -> REQ-018 values next cycle.

Source files
------------

// File: rtl/reorder_buffer.sv
// Reorder buffer: in-order issue/commit, out-of-order writeback,
// rename table with source forwarding and mispredict flush.
module reorder_buffer #(
    parameter int ROB_SIZE_BITS = 3
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    input  logic                     issue_valid,
    input  logic [4:0]               issue_rd,
    input  logic [31:0]              issue_pc,
    input  logic [31:0]              issue_pred_pc,
    input  logic                     issue_is_store,
    output logic                     issue_ready,
    output logic [ROB_SIZE_BITS-1:0] issue_tag,
    input  logic [4:0]               src1_reg,
    input  logic [4:0]               src2_reg,
    output logic                     src1_pending,
    output logic                     src2_pending,
    output logic [ROB_SIZE_BITS-1:0] src1_tag,
    output logic [ROB_SIZE_BITS-1:0] src2_tag,
    output logic                     src1_from_rob,
    output logic                     src2_from_rob,
    output logic [31:0]              src1_val,
    output logic [31:0]              src2_val,
    input  logic                     wb0_valid,
    input  logic                     wb1_valid,
    input  logic [ROB_SIZE_BITS-1:0] wb0_tag,
    input  logic [ROB_SIZE_BITS-1:0] wb1_tag,
    input  logic [31:0]              wb0_val,
    input  logic [31:0]              wb1_val,
    input  logic [31:0]              wb0_next_pc,
    input  logic [31:0]              wb1_next_pc,
    output logic [ROB_SIZE_BITS-1:0] head_tag,
    output logic                     commit_valid,
    output logic [4:0]               commit_rd,
    output logic [31:0]              commit_val,
    output logic                     commit_is_store,
    output logic                     flush_out,
    output logic [31:0]              flush_pc,
    output logic [ROB_SIZE_BITS:0]   count
);

    localparam int B = ROB_SIZE_BITS;
    localparam int N = 1 << B;
    localparam logic [B:0] FULL = (B+1)'(N);

    localparam logic [1:0] EMPTY  = 2'd0;
    localparam logic [1:0] ISSUED = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    logic [1:0]   state_q [N];
    logic [1:0]   state_d [N];
    logic [4:0]   rd_q    [N];
    logic [4:0]   rd_d    [N];
    logic [31:0]  pc_q    [N];
    logic [31:0]  pc_d    [N];
    logic [31:0]  pred_q  [N];
    logic [31:0]  pred_d  [N];
    logic [31:0]  act_q   [N];
    logic [31:0]  act_d   [N];
    logic [31:0]  val_q   [N];
    logic [31:0]  val_d   [N];
    logic         st_q    [N];
    logic         st_d    [N];
    logic [31:0]  busy_q, busy_d;
    logic [B-1:0] rtag_q  [32];
    logic [B-1:0] rtag_d  [32];
    logic [B-1:0] head_q, head_d;
    logic [B-1:0] tail_q, tail_d;
    logic [B:0]   count_q, count_d;

    logic issue_acc;
    logic [4:0] head_rd;

    // Returns {pending, from_rob, value} for one source register.
    function automatic logic [33:0] lookup(input logic [4:0] r);
        logic [B-1:0] t;
        t = rtag_q[r];
        if (r == 5'd0 || !busy_q[r])
            lookup = '0;
        else if (state_q[t] == DONE)
            lookup = {2'b01, val_q[t]};
        else if (wb0_valid && wb0_tag == t)
            lookup = {2'b01, wb0_val};
        else if (wb1_valid && wb1_tag == t)
            lookup = {2'b01, wb1_val};
        else
            lookup = {2'b10, 32'h0};
    endfunction

    // Status, commit and flush outputs decoded from the head entry.
    always_comb begin
        issue_ready     = (count_q < FULL);
        issue_tag       = tail_q;
        head_tag        = head_q;
        count           = count_q;
        head_rd         = rd_q[head_q];
        commit_valid    = rdy_in && (count_q != '0) &&
                          (state_q[head_q] == DONE);
        commit_is_store = st_q[head_q];
        commit_rd       = st_q[head_q] ? 5'd0 : head_rd;
        commit_val      = val_q[head_q];
        flush_out       = commit_valid &&
                          (act_q[head_q] != pred_q[head_q]);
        flush_pc        = act_q[head_q];
        issue_acc       = rdy_in && issue_valid &&
                          issue_ready && !flush_out;
    end

    // Source operand lookup against rename table and writebacks.
    always_comb begin
        {src1_pending, src1_from_rob, src1_val} = lookup(src1_reg);
        {src2_pending, src2_from_rob, src2_val} = lookup(src2_reg);
        src1_tag = rtag_q[src1_reg];
        src2_tag = rtag_q[src2_reg];
    end

    // Next-state: writeback, commit, issue, or a full flush.
    always_comb begin
        state_d = state_q;
        rd_d    = rd_q;
        pc_d    = pc_q;
        pred_d  = pred_q;
        act_d   = act_q;
        val_d   = val_q;
        st_d    = st_q;
        busy_d  = busy_q;
        rtag_d  = rtag_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (rdy_in && flush_out) begin
            for (int i = 0; i < N; i++)
                state_d[i] = EMPTY;
            busy_d  = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else if (rdy_in) begin
            // Port 1 first so port 0 overrides on a shared tag.
            if (wb1_valid && state_q[wb1_tag] == ISSUED) begin
                state_d[wb1_tag] = DONE;
                val_d[wb1_tag]   = wb1_val;
                act_d[wb1_tag]   = wb1_next_pc;
            end
            if (wb0_valid && state_q[wb0_tag] == ISSUED) begin
                state_d[wb0_tag] = DONE;
                val_d[wb0_tag]   = wb0_val;
                act_d[wb0_tag]   = wb0_next_pc;
            end
            if (commit_valid) begin
                state_d[head_q] = EMPTY;
                head_d = head_q + 1'b1;
                if (rtag_q[head_rd] == head_q &&
                    !(issue_acc && issue_rd == head_rd))
                    busy_d[head_rd] = 1'b0;
            end
            if (issue_acc) begin
                state_d[tail_q] = ISSUED;
                rd_d[tail_q]    = issue_rd;
                pc_d[tail_q]    = issue_pc;
                pred_d[tail_q]  = issue_pred_pc;
                st_d[tail_q]    = issue_is_store;
                tail_d = tail_q + 1'b1;
                if (issue_rd != 5'd0) begin
                    busy_d[issue_rd] = 1'b1;
                    rtag_d[issue_rd] = tail_q;
                end
            end
            count_d = count_q + (B+1)'(issue_acc)
                              - (B+1)'(commit_valid);
        end
    end

    // State registers; reset clears occupancy and rename busy bits.
    always_ff @(posedge clk_in) begin
        rd_q   <= rd_d;
        pc_q   <= pc_d;
        pred_q <= pred_d;
        act_q  <= act_d;
        val_q  <= val_d;
        st_q   <= st_d;
        rtag_q <= rtag_d;
        if (rst_in) begin
            for (int i = 0; i < N; i++)
                state_q[i] <= EMPTY;
            busy_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer with a commit scoreboard.
// Expected commits are queued by stimulus and popped by a monitor.
module tb_reorder_buffer;

    localparam int B = 3;

    logic         clk_in = 1'b0;
    logic         rst_in, rdy_in;
    logic         issue_valid, issue_is_store;
    logic [4:0]   issue_rd;
    logic [31:0]  issue_pc, issue_pred_pc;
    logic         issue_ready;
    logic [B-1:0] issue_tag;
    logic [4:0]   src1_reg, src2_reg;
    logic         src1_pending, src2_pending;
    logic [B-1:0] src1_tag, src2_tag;
    logic         src1_from_rob, src2_from_rob;
    logic [31:0]  src1_val, src2_val;
    logic         wb0_valid, wb1_valid;
    logic [B-1:0] wb0_tag, wb1_tag;
    logic [31:0]  wb0_val, wb1_val, wb0_next_pc, wb1_next_pc;
    logic [B-1:0] head_tag;
    logic         commit_valid, commit_is_store, flush_out;
    logic [4:0]   commit_rd;
    logic [31:0]  commit_val, flush_pc;
    logic [B:0]   count;

    reorder_buffer #(.ROB_SIZE_BITS(B)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .issue_pc(issue_pc), .issue_pred_pc(issue_pred_pc),
        .issue_is_store(issue_is_store),
        .issue_ready(issue_ready), .issue_tag(issue_tag),
        .src1_reg(src1_reg), .src2_reg(src2_reg),
        .src1_pending(src1_pending), .src2_pending(src2_pending),
        .src1_tag(src1_tag), .src2_tag(src2_tag),
        .src1_from_rob(src1_from_rob), .src2_from_rob(src2_from_rob),
        .src1_val(src1_val), .src2_val(src2_val),
        .wb0_valid(wb0_valid), .wb1_valid(wb1_valid),
        .wb0_tag(wb0_tag), .wb1_tag(wb1_tag),
        .wb0_val(wb0_val), .wb1_val(wb1_val),
        .wb0_next_pc(wb0_next_pc), .wb1_next_pc(wb1_next_pc),
        .head_tag(head_tag), .commit_valid(commit_valid),
        .commit_rd(commit_rd), .commit_val(commit_val),
        .commit_is_store(commit_is_store),
        .flush_out(flush_out), .flush_pc(flush_pc), .count(count)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] val;
        logic        st;
        logic        fl;
        logic [31:0] fpc;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [4:0] rd, input logic [31:0] val,
                        input logic st, input logic fl,
                        input logic [31:0] fpc);
        exp_t e;
        e.rd = rd; e.val = val; e.st = st; e.fl = fl; e.fpc = fpc;
        exp_q.push_back(e);
    endtask

    // Monitor: every presented commit must match the oldest expectation.
    always @(negedge clk_in) begin
        if (commit_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_commit", 32'(commit_rd), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("commit_rd", 32'(commit_rd), 32'(e.rd));
                chk("commit_val", commit_val, e.val);
                chk("commit_is_store", 32'(commit_is_store), 32'(e.st));
                chk("commit_flush", 32'(flush_out), 32'(e.fl));
                if (e.fl)
                    chk("commit_flush_pc", flush_pc, e.fpc);
            end
        end
    end

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic neg();
        @(negedge clk_in);
    endtask

    task automatic idle();
        issue_valid = 1'b0; issue_is_store = 1'b0;
        wb0_valid = 1'b0; wb1_valid = 1'b0;
    endtask

    task automatic iss(input logic [4:0] rd, input logic [31:0] pc,
                       input logic st);
        issue_valid = 1'b1; issue_rd = rd; issue_pc = pc;
        issue_pred_pc = pc + 32'd4; issue_is_store = st;
    endtask

    task automatic wb0(input logic [B-1:0] t, input logic [31:0] v,
                       input logic [31:0] npc);
        wb0_valid = 1'b1; wb0_tag = t; wb0_val = v; wb0_next_pc = npc;
    endtask

    task automatic wb1(input logic [B-1:0] t, input logic [31:0] v,
                       input logic [31:0] npc);
        wb1_valid = 1'b1; wb1_tag = t; wb1_val = v; wb1_next_pc = npc;
    endtask

    task automatic do_reset();
        idle();
        rst_in = 1'b1;
        step();
        rst_in = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tagn);
        chk({tagn, "_ready"}, 32'(issue_ready), 1);
        chk({tagn, "_issue_tag"}, 32'(issue_tag), 0);
        chk({tagn, "_head_tag"}, 32'(head_tag), 0);
        chk({tagn, "_count"}, 32'(count), 0);
        chk({tagn, "_commit_valid"}, 32'(commit_valid), 0);
        chk({tagn, "_flush"}, 32'(flush_out), 0);
        chk({tagn, "_s1_pending"}, 32'(src1_pending), 0);
        chk({tagn, "_s1_from_rob"}, 32'(src1_from_rob), 0);
        chk({tagn, "_s2_pending"}, 32'(src2_pending), 0);
        chk({tagn, "_s2_from_rob"}, 32'(src2_from_rob), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rdy_in = 1'b1; issue_rd = '0; issue_pc = '0; issue_pred_pc = '0;
        wb0_tag = '0; wb1_tag = '0; wb0_val = '0; wb1_val = '0;
        wb0_next_pc = '0; wb1_next_pc = '0;
        src1_reg = 5'd5; src2_reg = 5'd0;
        do_reset();
        step();
        neg();
        chk_reset_vals("rst0");
        step();

        // Rename lookup and same-cycle writeback forwarding.
        iss(5, 32'h100, 0);
        neg(); chk("t1_issue_tag", 32'(issue_tag), 0);
        step(); idle();
        neg();
        chk("t1_pending", 32'(src1_pending), 1);
        chk("t1_tag", 32'(src1_tag), 0);
        chk("t1_from_rob0", 32'(src1_from_rob), 0);
        step();
        wb0(0, 32'h1234, 32'h104);
        push(5, 32'h1234, 0, 0, 0);
        neg();
        chk("t1_fwd_pending", 32'(src1_pending), 0);
        chk("t1_fwd_from_rob", 32'(src1_from_rob), 1);
        chk("t1_fwd_val", src1_val, 32'h1234);
        step(); idle();
        neg();
        chk("t1_done_from_rob", 32'(src1_from_rob), 1);
        chk("t1_done_val", src1_val, 32'h1234);
        step();
        neg();
        chk("t1_count", 32'(count), 0);
        chk("t1_busy_clear", 32'(src1_pending | src1_from_rob), 0);

        // Out-of-order writeback, in-order commit, store commit_rd=0.
        do_reset();
        iss(1, 32'h200, 0); step();
        iss(6, 32'h204, 1); step(); idle();
        push(1, 32'hAAAA, 0, 0, 0);
        push(0, 32'hBBBB, 1, 0, 0);
        wb0(1, 32'hBBBB, 32'h208);
        neg();
        chk("t2_count", 32'(count), 2);
        chk("t2_no_commit0", 32'(commit_valid), 0);
        step(); idle();
        wb1(0, 32'hAAAA, 32'h204);
        neg(); chk("t2_no_commit1", 32'(commit_valid), 0);
        step(); idle();
        step();
        step();
        neg(); chk("t2_count_end", 32'(count), 0);

        // Mispredict flush discards same-cycle issue and writeback.
        do_reset();
        iss(7, 32'h100, 0); step();
        iss(8, 32'h104, 0); step(); idle();
        wb0(0, 32'h55, 32'h200); step(); idle();
        push(7, 32'h55, 0, 1, 32'h200);
        iss(9, 32'h300, 0);
        wb1(1, 32'h66, 32'h108);
        neg();
        chk("t3_flush", 32'(flush_out), 1);
        chk("t3_flush_pc", flush_pc, 32'h200);
        step(); idle();
        src1_reg = 5'd7; src2_reg = 5'd8;
        neg();
        chk("t3_count", 32'(count), 0);
        chk("t3_s1", 32'({src1_pending, src1_from_rob}), 0);
        chk("t3_s2", 32'({src2_pending, src2_from_rob}), 0);
        chk("t3_issue_tag", 32'(issue_tag), 0);
        chk("t3_head_tag", 32'(head_tag), 0);
        src1_reg = 5'd9;
        neg(); chk("t3_s1_x9", 32'(src1_pending), 0);

        // Rename tag survives an older commit; port 0 wins writeback.
        do_reset();
        iss(1, 32'h400, 0); step();
        iss(2, 32'h404, 0); step();
        iss(3, 32'h408, 0); step();
        iss(4, 32'h40C, 0); step();
        iss(3, 32'h410, 0); step(); idle();
        wb0(0, 32'h1, 32'h404);
        wb1(1, 32'h2, 32'h408);
        step(); idle();
        push(1, 32'h1, 0, 0, 0);
        push(2, 32'h2, 0, 0, 0);
        push(3, 32'h33, 0, 0, 0);
        wb0(2, 32'h33, 32'h40C);
        wb1(1, 32'hDEAD, 32'h408);
        step(); idle();
        step();
        src1_reg = 5'd3;
        step();
        neg();
        chk("t4_pending", 32'(src1_pending), 1);
        chk("t4_tag", 32'(src1_tag), 4);
        chk("t4_head", 32'(head_tag), 3);
        chk("t4_count", 32'(count), 2);
        step();
        wb0(4, 32'h4444, 32'h414);
        wb1(4, 32'h9999, 32'h414);
        neg();
        chk("t4_fwd_val", src1_val, 32'h4444);
        chk("t4_fwd_from_rob", 32'(src1_from_rob), 1);
        step(); idle();
        neg();
        chk("t4_done_val", src1_val, 32'h4444);
        chk("t4_done_pending", 32'(src1_pending), 0);
        step();
        push(4, 32'h3333, 0, 0, 0);
        push(3, 32'h4444, 0, 0, 0);
        wb0(3, 32'h3333, 32'h410);
        step(); idle();
        step();
        step();
        neg();
        chk("t4_count_end", 32'(count), 0);
        chk("t4_busy_clear", 32'(src1_pending | src1_from_rob), 0);

        // Full buffer rejects issue even while head commits.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            iss(5'(10 + i), 32'h1000 + 32'(4 * i), 0);
            step();
        end
        idle();
        neg();
        chk("t5_count_full", 32'(count), 8);
        chk("t5_ready_full", 32'(issue_ready), 0);
        chk("t5_tail_wrap", 32'(issue_tag), 0);
        wb0(0, 32'hA0, 32'h1004);
        step(); idle();
        push(10, 32'hA0, 0, 0, 0);
        iss(20, 32'h2000, 0);
        neg();
        chk("t5_commit_when_full", 32'(commit_valid), 1);
        chk("t5_ready_commit", 32'(issue_ready), 0);
        step(); idle();
        src1_reg = 5'd20;
        neg();
        chk("t5_count_7", 32'(count), 7);
        chk("t5_head_1", 32'(head_tag), 1);
        chk("t5_tail_0", 32'(issue_tag), 0);
        chk("t5_rejected_x20", 32'(src1_pending), 0);
        chk("t5_ready_again", 32'(issue_ready), 1);
        iss(21, 32'h2004, 0);
        step(); idle();
        src1_reg = 5'd21;
        neg();
        chk("t5_count_refill", 32'(count), 8);
        chk("t5_x21_tag", 32'(src1_tag), 0);
        chk("t5_x21_pending", 32'(src1_pending), 1);

        // Pause freezes state and suppresses commit.
        wb0(1, 32'hA1, 32'h1008);
        step(); idle();
        rdy_in = 1'b0;
        iss(22, 32'h3000, 0);
        wb0(2, 32'hA2, 32'h100C);
        for (int k = 0; k < 3; k++) begin
            neg();
            chk("t6_pause_commit", 32'(commit_valid), 0);
            chk("t6_pause_flush", 32'(flush_out), 0);
            chk("t6_pause_count", 32'(count), 8);
            step();
        end
        idle();
        rdy_in = 1'b1;
        push(11, 32'hA1, 0, 0, 0);
        neg(); chk("t6_resume_commit", 32'(commit_valid), 1);
        step();

        // Reset mid-run wins over rdy_in and other inputs.
        rst_in = 1'b1; rdy_in = 1'b0;
        iss(23, 32'h4000, 0);
        wb0(2, 32'hA2, 32'h100C);
        step();
        rst_in = 1'b0; rdy_in = 1'b1; idle();
        src1_reg = 5'd21; src2_reg = 5'd12;
        neg();
        chk_reset_vals("rst1");
        step();
        chk("sb_empty", 32'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
